// File: rtl/gate_mux_selftest_if.sv
// Purpose : bundles the self-test stage's run handshake, gate drive/return and result signals.
// Latency : none, pure wiring.
// Backpres: none; start is a level request only honoured while the stage is idle.
// Ports (slave = self-test stage, master = its user):
//   start in; a_out/b_out/busy/done/pass/err_mask/err_count/fail_vec/fail_valid out;
//   gate_in in (results of the gate block driven by a_out/b_out).
interface gate_mux_selftest_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             a_out;
  logic             b_out;
  logic [7:0]       gate_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [7:0]       err_mask;
  logic [CNT_W-1:0] err_count;
  logic [1:0]       fail_vec;
  logic             fail_valid;

  modport slave (
    input  start, gate_in,
    output a_out, b_out, busy, done, pass, err_mask, err_count, fail_vec, fail_valid
  );

  modport master (
    output start, gate_in,
    input  a_out, b_out, busy, done, pass, err_mask, err_count, fail_vec, fail_valid
  );
endinterface

// File: rtl/gate_mux_selftest.sv
// Purpose : sweeps {a,b} through all four combinations PASSES times and checks 8 gate results.
// Latency : done pulses 4*PASSES*(SETTLE_CYCLES+1)+1 cycles after the edge that accepts start.
// Backpres: start is ignored while busy or done; there is no abort other than rst.
// Ports: clk, rst (synchronous, active-high), io (slave modport of gate_mux_selftest_if).
//   gate_in bit order: [0]buf [1]inv [2]and [3]nand [4]or [5]nor [6]xor [7]xnor.
module gate_mux_selftest #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  gate_mux_selftest_if.slave    io
);

  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(PASSES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        vec_q;
  logic [PASS_W-1:0] pass_idx_q;
  logic [SET_W-1:0]  settle_q;
  logic [7:0]        err_mask_q;
  logic [CNT_W-1:0]  err_count_q;
  logic [1:0]        fail_vec_q;
  logic              fail_valid_q;
  logic              pass_q;

  logic              a_ref, b_ref;
  logic [7:0]        exp_res;
  logic [7:0]        mm;
  logic              last_vec;

  // Ideal truth table for the vector currently on a_out/b_out.
  always_comb begin
    a_ref    = vec_q[1];
    b_ref    = vec_q[0];
    exp_res  = {~(a_ref ^ b_ref), a_ref ^ b_ref, ~(a_ref | b_ref), a_ref | b_ref,
                ~(a_ref & b_ref), a_ref & b_ref, ~a_ref, a_ref};
    mm       = io.gate_in ^ exp_res;
    last_vec = (vec_q == 2'd3) && (pass_idx_q == PASS_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.start) state_d = DRIVE;
      DRIVE:   if (settle_q == SETTLE_LAST) state_d = SAMPLE;
      SAMPLE:  state_d = last_vec ? DONE : DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sweep counters and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q        <= '0;
      pass_idx_q   <= '0;
      settle_q     <= '0;
      err_mask_q   <= '0;
      err_count_q  <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.start) begin
            vec_q        <= '0;
            pass_idx_q   <= '0;
            settle_q     <= '0;
            err_mask_q   <= '0;
            err_count_q  <= '0;
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
            pass_q       <= 1'b0;
          end
        end
        DRIVE: begin
          // settle_q wraps to 0 on the last drive cycle, ready for the next vector
          settle_q <= (settle_q == SETTLE_LAST) ? '0 : settle_q + 1'b1;
        end
        SAMPLE: begin
          err_mask_q <= err_mask_q | mm;
          if (mm != 8'h00) begin
            if (err_count_q != CNT_MAX) err_count_q <= err_count_q + 1'b1;
            if (!fail_valid_q) begin
              fail_vec_q   <= vec_q;
              fail_valid_q <= 1'b1;
            end
          end
          if (!last_vec) begin
            vec_q <= vec_q + 2'd1;
            if (vec_q == 2'd3) pass_idx_q <= pass_idx_q + 1'b1;
          end
        end
        DONE: pass_q <= (err_mask_q == 8'h00);
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    io.busy  = (state_q == DRIVE) || (state_q == SAMPLE);
    io.done  = (state_q == DONE);
    io.a_out = io.busy ? vec_q[1] : 1'b0;
    io.b_out = io.busy ? vec_q[0] : 1'b0;
    // pass is already meaningful in the done cycle, then held by pass_q
    io.pass  = (state_q == DONE) ? (err_mask_q == 8'h00) : pass_q;
  end

  assign io.err_mask   = err_mask_q;
  assign io.err_count  = err_count_q;
  assign io.fail_vec   = fail_vec_q;
  assign io.fail_valid = fail_valid_q;

endmodule

// File: tb/tb_gate_mux_selftest.sv
// Purpose : exercises two self-test stages (defaults, and PASSES=2/CNT_W=2) against a schedule model.
// Latency : model predicts every output per cycle from the cycle count since start.
// Backpres: start/rst pulses are issued both in directed runs and at random.
module tb_gate_mux_selftest;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   mode = 0;
  logic [7:0] grand = 8'h00;
  bit   chk_en = 1'b0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  gate_mux_selftest_if #(.CNT_W(8)) if0 ();
  gate_mux_selftest_if #(.CNT_W(2)) if1 ();

  gate_mux_selftest #(.SETTLE_CYCLES(S), .PASSES(1), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .io(if0));
  gate_mux_selftest #(.SETTLE_CYCLES(S), .PASSES(2), .CNT_W(2)) dut1 (.clk(clk), .rst(rst), .io(if1));

  // Gate block under test: ideal gates with selectable faults
  function automatic logic [7:0] gate_fn(int md, logic a, logic b, logic [7:0] rnd);
    logic [7:0] g;
    g[0] = a;        g[1] = !a;
    g[2] = a && b;   g[3] = !(a && b);
    g[4] = a || b;   g[5] = !(a || b);
    g[6] = (a != b); g[7] = (a == b);
    case (md)
      1: g[2] = 1'b0;               // and stuck at 0
      2: g = {g[6], g[7], g[5:0]};  // xor/xnor swapped
      3: g = ~g;                    // every output inverted
      4: g = rnd;
      default: ;
    endcase
    return g;
  endfunction

  always @(negedge clk) grand <= 8'($urandom);

  assign if0.start   = start;
  assign if1.start   = start;
  assign if0.gate_in = gate_fn(mode, if0.a_out, if0.b_out, grand);
  assign if1.gate_in = gate_fn(mode, if1.a_out, if1.b_out, grand);

  logic [23:0] obs [2];
  logic [7:0]  gin [2];
  assign obs[0] = {if0.busy, if0.done, if0.pass, if0.a_out, if0.b_out, if0.err_mask,
                   if0.err_count, if0.fail_vec, if0.fail_valid};
  assign obs[1] = {if1.busy, if1.done, if1.pass, if1.a_out, if1.b_out, if1.err_mask,
                   6'b0, if1.err_count, if1.fail_vec, if1.fail_valid};
  assign gin[0] = if0.gate_in;
  assign gin[1] = if1.gate_in;

  // ---------------- behavioural model ----------------
  // t = cycles since the accepting edge (0 = idle); run is L busy cycles then one done cycle.
  int         npass [2] = '{1, 2};
  int         cmax  [2] = '{255, 3};
  int         t     [2] = '{0, 0};
  logic [7:0] mmask [2] = '{8'h00, 8'h00};
  int         mcnt  [2] = '{0, 0};
  logic [1:0] mfv   [2] = '{2'b00, 2'b00};
  logic       mfval [2] = '{1'b0, 1'b0};
  logic       mpass [2] = '{1'b0, 1'b0};

  function automatic int run_len(int i);
    return 4 * npass[i] * (S + 1);
  endfunction

  function automatic logic [23:0] model_obs(int i);
    int   l;
    int   v;
    logic bsy, dn, ps;
    l   = run_len(i);
    bsy = (t[i] >= 1) && (t[i] <= l);
    dn  = (t[i] == l + 1);
    v   = bsy ? ((t[i] - 1) / (S + 1)) % 4 : 0;
    ps  = dn ? (mmask[i] == 8'h00) : mpass[i];
    return {bsy, dn, ps, v[1:0], mmask[i], 8'(mcnt[i]), mfv[i], mfval[i]};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int         l, v;
      logic       a, b;
      logic [7:0] ideal, mmv;
      l = run_len(i);
      if (rst) begin
        t[i] = 0; mmask[i] = 8'h00; mcnt[i] = 0; mfv[i] = 2'b00; mfval[i] = 1'b0; mpass[i] = 1'b0;
      end else if (t[i] == 0) begin
        if (start) begin
          t[i] = 1; mmask[i] = 8'h00; mcnt[i] = 0; mfv[i] = 2'b00; mfval[i] = 1'b0; mpass[i] = 1'b0;
        end
      end else if (t[i] <= l) begin
        if ((t[i] - 1) % (S + 1) == S) begin
          v     = ((t[i] - 1) / (S + 1)) % 4;
          a     = v[1];
          b     = v[0];
          ideal = gate_fn(0, a, b, 8'h00);
          mmv   = gin[i] ^ ideal;
          mmask[i] = mmask[i] | mmv;
          if (mmv != 8'h00) begin
            if (mcnt[i] < cmax[i]) mcnt[i] = mcnt[i] + 1;
            if (!mfval[i]) begin
              mfv[i]   = v[1:0];
              mfval[i] = 1'b1;
            end
          end
        end
        t[i] = t[i] + 1;
      end else begin
        mpass[i] = (mmask[i] == 8'h00);
        t[i] = 0;
      end
    end
  end

  // One compare process: every cycle, all outputs of both stages
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [23:0] e;
        e = model_obs(i);
        checks++;
        if (obs[i] === e) passes++;
        else $display("FAIL outputs dut%0d t=%0d: got busy/done/pass/a/b/mask/cnt/fv/fval=%h required %h",
                      i, t[i], obs[i], e);
      end
    end
  end

  // Hand-computed literal expectations
  task automatic lit(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  // Start during cycle 0; extra start pulses in cycles x1/x2, rst in cycle rc.
  // n0/n1 = cycle in which each stage's done was seen (0 = never within budget).
  task automatic run(input int x1, input int x2, input int rc, output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (n == x1) || (n == x2);
      rst   = (n == rc);
      if (if0.done && n0 == 0) n0 = n;
      if (if1.done && n1 == 0) n1 = n;
      if (n0 != 0 && n1 != 0) break;
    end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n0, n1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    lit("rst_outputs0", int'(obs[0]), 0);
    lit("rst_outputs1", int'(obs[1]), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: ideal gates
    mode = 0;
    run(0, 0, 0, n0, n1);
    lit("t1_done_cycle0", n0, 13);
    lit("t1_done_cycle1", n1, 25);
    lit("t1_pass0", int'(if0.pass), 1);
    lit("t1_mask0", int'(if0.err_mask), 0);
    lit("t1_fval0", int'(if0.fail_valid), 0);

    // 2: and stuck at 0
    mode = 1;
    run(0, 0, 0, n0, n1);
    lit("t2_mask0", int'(if0.err_mask), 'h04);
    lit("t2_cnt0", int'(if0.err_count), 1);
    lit("t2_fvec0", int'(if0.fail_vec), 3);
    lit("t2_fval0", int'(if0.fail_valid), 1);
    lit("t2_pass0", int'(if0.pass), 0);
    lit("t2_cnt1", int'(if1.err_count), 2);

    // 3: xor/xnor swapped
    mode = 2;
    run(0, 0, 0, n0, n1);
    lit("t3_mask0", int'(if0.err_mask), 'hC0);
    lit("t3_cnt0", int'(if0.err_count), 4);
    lit("t3_fvec0", int'(if0.fail_vec), 0);

    // 4: start while busy and in the done cycle is ignored; next start clears results
    mode = 0;
    run(5, 13, 0, n0, n1);
    lit("t4_done_cycle0", n0, 13);
    lit("t4_pass0", int'(if0.pass), 1);
    lit("t4_busy0_after", int'(if0.busy), 0);
    run(0, 0, 0, n0, n1);
    lit("t4_rerun_mask0", int'(if0.err_mask), 0);

    // 5: rst in second drive cycle of vec 2, then a clean run
    run(0, 0, 8, n0, n1);
    lit("t5_no_done0", n0, 0);
    lit("t5_outputs0", int'(obs[0]), 0);
    run(0, 0, 0, n0, n1);
    lit("t5_done_cycle0", n0, 13);
    lit("t5_pass0", int'(if0.pass), 1);

    // 6: every gate inverted; small counter saturates
    mode = 3;
    run(0, 0, 0, n0, n1);
    lit("t6_done_cycle1", n1, 25);
    lit("t6_mask1", int'(if1.err_mask), 'hFF);
    lit("t6_cnt1", int'(if1.err_count), 3);
    lit("t6_fvec1", int'(if1.fail_vec), 0);
    lit("t6_cnt0", int'(if0.err_count), 4);

    // Random start/rst/fault traffic, checked only by the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 31) == 0) mode = $urandom_range(0, 4);
    end
    start = 1'b0;
    rst   = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
